// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: grant encoding,
// writeback request record and the "does this write a real register" helper.
package wb_port_arbiter_pkg;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int         PKG_XLEN = 32;

    typedef enum logic [1:0] {
        WB_PORT_NONE = 2'd0,
        WB_PORT_PIPE = 2'd1,
        WB_PORT_LU   = 2'd2
    } wb_port_t;

    typedef struct packed {
        logic                vld;
        logic [4:0]          rd;
        logic [PKG_XLEN-1:0] data;
    } wb_req_t;

    // x0 is hard-wired zero, so a write to it never needs the port.
    function automatic logic writes_reg(input logic vld, input logic [4:0] rd);
        return vld && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_lu_fifo.sv
// Small synchronous FIFO holding long-latency results (rd + data) until they
// win the register-file write port. Depth is a power of two so pointers wrap freely.
module wb_lu_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [4:0]    push_rd,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [4:0]    head_rd,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [4:0]    rd_mem   [DEPTH];
    logic [W-1:0]  data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    assign head_rd   = rd_mem[head];
    assign head_data = data_mem[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

    // Storage carries no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= push_rd;
            data_mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between in-order writeback and
// queued long-latency results; pipeline has priority, bounded by a starvation limit.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_vld,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_stall,
    input  logic            lu_vld,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_rdy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic            wb_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            force_lu;
    logic [CW-1:0]   count;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [SW-1:0]   starve;
    wb_port_t        grant;

    assign wb_req = writes_reg(wb_vld, wb_rd);
    assign lu_rdy = !full;
    // An accepted LU result for x0 is consumed here and never queued.
    assign push   = writes_reg(lu_vld && lu_rdy, lu_rd);
    assign pop    = (grant == WB_PORT_LU);

    wb_lu_fifo #(
        .W     (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign force_lu = (count == CW'(BUF_DEPTH)) || (starve == SW'(STARVE_LIMIT));

    always_comb begin
        grant    = WB_PORT_NONE;
        wb_stall = 1'b0;
        if (empty) begin
            if (wb_req) grant = WB_PORT_PIPE;
        end else if (!wb_req || force_lu) begin
            grant    = WB_PORT_LU;
            wb_stall = wb_req;
        end else begin
            grant = WB_PORT_PIPE;
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
            starve  <= '0;
        end else begin
            rf_we <= (grant != WB_PORT_NONE);
            if (grant == WB_PORT_PIPE) begin
                rf_rd   <= wb_rd;
                rf_data <= wb_data;
            end else if (grant == WB_PORT_LU) begin
                rf_rd   <= head_rd;
                rf_data <= head_data;
            end
            if (empty || grant == WB_PORT_LU) begin
                starve <= '0;
            end else if (starve != SW'(STARVE_LIMIT)) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model of the write-port sharing rules.
module tb_wb_port_arbiter;

    localparam int XLEN         = 32;
    localparam int BUF_DEPTH    = 2;
    localparam int STARVE_LIMIT = 4;

    logic            clk;
    logic            rst;
    logic            wb_vld;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_stall;
    logic            lu_vld;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            lu_rdy;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;

    int errors;
    int checks;

    wb_port_arbiter #(
        .XLEN         (XLEN),
        .BUF_DEPTH    (BUF_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_vld   (wb_vld),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_stall (wb_stall),
        .lu_vld   (lu_vld),
        .lu_rd    (lu_rd),
        .lu_data  (lu_data),
        .lu_rdy   (lu_rdy),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_data  (rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queued LU results, starvation count, expected write port.
    logic [4:0]      q_rd   [$];
    logic [XLEN-1:0] q_data [$];
    int              m_starve;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;

    // 0 = no write, 1 = pipeline, 2 = queued LU result
    function automatic int m_grant();
        bit req;
        req = wb_vld && (wb_rd != 5'd0);
        if (q_rd.size() == 0) return req ? 1 : 0;
        if (!req) return 2;
        if (q_rd.size() == BUF_DEPTH || m_starve == STARVE_LIMIT) return 2;
        return 1;
    endfunction

    function automatic bit m_stall();
        return (m_grant() == 2) && wb_vld && (wb_rd != 5'd0);
    endfunction

    function automatic bit m_rdy();
        return q_rd.size() < BUF_DEPTH;
    endfunction

    task automatic tick();
        int g;
        bit was_empty;
        bit push;
        g         = m_grant();
        was_empty = (q_rd.size() == 0);
        push      = lu_vld && m_rdy() && (lu_rd != 5'd0);
        if (!rst) begin
            q_rd.delete();
            q_data.delete();
            m_starve = 0;
            m_we     = 1'b0;
            m_rd     = '0;
            m_data   = '0;
        end else begin
            m_we = (g != 0);
            if (g == 1) begin
                m_rd   = wb_rd;
                m_data = wb_data;
            end else if (g == 2) begin
                m_rd   = q_rd.pop_front();
                m_data = q_data.pop_front();
            end
            if (was_empty || g == 2) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
            if (push) begin
                q_rd.push_back(lu_rd);
                q_data.push_back(lu_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_vld  = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        lu_vld  = 1'b0;
        lu_rd   = '0;
        lu_data = '0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        wb_vld  = 1'b1;
        wb_rd   = 5'd9;
        wb_data = 32'hDEAD_BEEF;
        tick();
        tick();
        checks += 5;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: rf_we=%0b expected 0", rf_we); end
        if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: rf_rd=%0d expected 0", rf_rd); end
        if (rf_data !== 32'd0) begin errors++; $display("FAIL reset_data: rf_data=%h expected 0", rf_data); end
        if (lu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: lu_rdy=%0b expected 1", lu_rdy); end
        if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: wb_stall=%0b expected 0", wb_stall); end
        rst     = 1'b1;
        wb_rd   = 5'd5;
        wb_data = 32'hA5A5_0001;
        tick();
        checks += 3;
        if (rf_we !== 1'b1) begin errors++; $display("FAIL first_wb_we: rf_we=%0b expected 1", rf_we); end
        if (rf_rd !== 5'd5) begin errors++; $display("FAIL first_wb_rd: rf_rd=%0d expected 5", rf_rd); end
        if (rf_data !== 32'hA5A5_0001) begin errors++; $display("FAIL first_wb_data: rf_data=%h expected a5a50001", rf_data); end
        idle_inputs();
        tick();
        checks += 2;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we: rf_we=%0b expected 0", rf_we); end
        if (rf_rd !== 5'd5) begin errors++; $display("FAIL idle_hold_rd: rf_rd=%0d expected 5", rf_rd); end
    endtask

    task automatic test_x0_drop();
        wb_vld  = 1'b1;
        wb_rd   = 5'd0;
        wb_data = 32'h1111_2222;
        lu_vld  = 1'b1;
        lu_rd   = 5'd0;
        lu_data = 32'h3333_4444;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks += 2;
            if (wb_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: wb_stall=%0b expected 0", wb_stall); end
            if (lu_rdy !== 1'b1) begin errors++; $display("FAIL x0_rdy: lu_rdy=%0b expected 1", lu_rdy); end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            checks += 1;
            if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_no_write: rf_we=%0b expected 0 cycle %0d", rf_we, c); end
            tick();
        end
    endtask

    task automatic test_idle_lu();
        lu_vld  = 1'b1;
        lu_rd   = 5'd7;
        lu_data = 32'h0000_1234;
        tick();
        lu_vld = 1'b0;
        checks += 1;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL lu_no_bypass: rf_we=%0b expected 0", rf_we); end
        tick();
        checks += 3;
        if (rf_we !== 1'b1) begin errors++; $display("FAIL lu_idle_we: rf_we=%0b expected 1", rf_we); end
        if (rf_rd !== 5'd7) begin errors++; $display("FAIL lu_idle_rd: rf_rd=%0d expected 7", rf_rd); end
        if (rf_data !== 32'h0000_1234) begin errors++; $display("FAIL lu_idle_data: rf_data=%h expected 00001234", rf_data); end
        tick();
        checks += 1;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL lu_idle_once: rf_we=%0b expected 0", rf_we); end
    endtask

    task automatic test_starvation();
        int k;
        bit es;
        logic [4:0]      e_rd;
        logic [XLEN-1:0] e_data;
        wb_vld  = 1'b1;
        wb_rd   = 5'd20;
        wb_data = 32'd0;
        lu_vld  = 1'b1;
        lu_rd   = 5'd12;
        lu_data = 32'h0000_C0DE;
        tick();
        lu_vld = 1'b0;
        k = 1;
        for (int c = 1; c <= 6; c++) begin
            wb_rd   = 5'(20 + k);
            wb_data = 32'(k);
            #1;
            es = (c == 5);
            checks += 1;
            if (wb_stall !== es) begin errors++; $display("FAIL starve_stall: cycle %0d wb_stall=%0b expected %0b", c, wb_stall, es); end
            tick();
            e_rd   = es ? 5'd12 : 5'(20 + k);
            e_data = es ? 32'h0000_C0DE : 32'(k);
            checks += 3;
            if (rf_we !== 1'b1) begin errors++; $display("FAIL starve_we: cycle %0d rf_we=%0b expected 1", c, rf_we); end
            if (rf_rd !== e_rd) begin errors++; $display("FAIL starve_rd: cycle %0d rf_rd=%0d expected %0d", c, rf_rd, e_rd); end
            if (rf_data !== e_data) begin errors++; $display("FAIL starve_data: cycle %0d rf_data=%h expected %h", c, rf_data, e_data); end
            if (!es) k++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_full_fifo();
        logic [4:0]      exp_rd   [7] = '{5'd10, 5'd11, 5'd3, 5'd12, 5'd4, 5'd13, 5'd9};
        logic [XLEN-1:0] exp_data [7] = '{32'h100A, 32'h100B, 32'h33, 32'h100C, 32'h44, 32'h100D, 32'h99};
        bit              exp_stl  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bit              exp_rdy  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int k;
        k = 10;
        for (int c = 0; c < 7; c++) begin
            wb_vld  = (c < 6);
            wb_rd   = 5'(k);
            wb_data = 32'h1000 + 32'(k);
            lu_vld  = (c < 4);
            lu_rd   = (c == 0) ? 5'd3 : (c == 1) ? 5'd4 : 5'd9;
            lu_data = (c == 0) ? 32'h33 : (c == 1) ? 32'h44 : 32'h99;
            #1;
            checks += 2;
            if (wb_stall !== exp_stl[c]) begin errors++; $display("FAIL full_stall: cycle %0d wb_stall=%0b expected %0b", c, wb_stall, exp_stl[c]); end
            if (lu_rdy !== exp_rdy[c]) begin errors++; $display("FAIL full_rdy: cycle %0d lu_rdy=%0b expected %0b", c, lu_rdy, exp_rdy[c]); end
            tick();
            checks += 3;
            if (rf_we !== 1'b1) begin errors++; $display("FAIL full_we: cycle %0d rf_we=%0b expected 1", c, rf_we); end
            if (rf_rd !== exp_rd[c]) begin errors++; $display("FAIL full_rd: cycle %0d rf_rd=%0d expected %0d", c, rf_rd, exp_rd[c]); end
            if (rf_data !== exp_data[c]) begin errors++; $display("FAIL full_data: cycle %0d rf_data=%h expected %h", c, rf_data, exp_data[c]); end
            if (!exp_stl[c]) k++;
        end
        idle_inputs();
        tick();
        checks += 1;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL full_drained: rf_we=%0b expected 0", rf_we); end
    endtask

    task automatic test_reset_mid();
        wb_vld  = 1'b1;
        wb_rd   = 5'd15;
        wb_data = 32'h15;
        lu_vld  = 1'b1;
        lu_rd   = 5'd6;
        lu_data = 32'h66;
        tick();
        wb_rd   = 5'd16;
        lu_rd   = 5'd8;
        lu_data = 32'h88;
        tick();
        #1;
        checks += 1;
        if (lu_rdy !== 1'b0) begin errors++; $display("FAIL mid_full: lu_rdy=%0b expected 0", lu_rdy); end
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks += 3;
        if (lu_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy: lu_rdy=%0b expected 1", lu_rdy); end
        if (wb_stall !== 1'b0) begin errors++; $display("FAIL mid_stall: wb_stall=%0b expected 0", wb_stall); end
        if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_we: rf_we=%0b expected 0", rf_we); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks += 1;
            if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d rf_we=%0b rf_rd=%0d expected no write", c, rf_we, rf_rd); end
        end
    endtask

    task automatic test_random();
        bit hold_wb;
        bit hold_lu;
        bit es;
        bit er;
        hold_wb = 1'b0;
        hold_lu = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!hold_wb) begin
                wb_vld  = ($urandom_range(3) != 0);
                wb_rd   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                wb_data = $urandom;
            end
            if (!hold_lu) begin
                lu_vld  = (c < 300) ? ($urandom_range(1) == 0) : ($urandom_range(3) == 0);
                lu_rd   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                lu_data = $urandom;
            end
            #1;
            es = m_stall();
            er = m_rdy();
            checks += 2;
            if (wb_stall !== es) begin errors++; $display("FAIL rand_stall: cycle %0d wb_stall=%0b expected %0b", c, wb_stall, es); end
            if (lu_rdy !== er) begin errors++; $display("FAIL rand_rdy: cycle %0d lu_rdy=%0b expected %0b", c, lu_rdy, er); end
            hold_wb = es;
            hold_lu = lu_vld && !er;
            tick();
            checks += 3;
            if (rf_we !== m_we) begin errors++; $display("FAIL rand_we: cycle %0d rf_we=%0b expected %0b", c, rf_we, m_we); end
            if (rf_rd !== m_rd) begin errors++; $display("FAIL rand_rd: cycle %0d rf_rd=%0d expected %0d", c, rf_rd, m_rd); end
            if (rf_data !== m_data) begin errors++; $display("FAIL rand_data: cycle %0d rf_data=%h expected %h", c, rf_data, m_data); end
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        m_starve = 0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        rst      = 1'b0;
        idle_inputs();
        test_reset();
        test_x0_drop();
        test_idle_lu();
        test_starvation();
        test_full_fifo();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WB_data/WB_rd path) and a long-latency unit (LU, e.g. multiply/divide) that completes out of band.
- LU results are queued in a small FIFO. The pipeline has priority, bounded by a starvation limit.
- When the LU wins against a live pipeline write, the block stalls the pipeline.
- Sits between the writeback stage and the register file; drives the registered write port.

Parameters:
- XLEN, 32, data width
- BUF_DEPTH, 2, LU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied before forced grant (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- wb_vld  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline destination register
- wb_data  in  XLEN  pipeline writeback data
- wb_stall  out  1  combinational; pipeline must hold its WB instruction this cycle
- lu_vld  in  1  LU result valid; accepted only when lu_rdy=1
- lu_rd  in  5  LU destination register
- lu_data  in  XLEN  LU result data
- lu_rdy  out  1  FIFO not full (count < BUF_DEPTH), from registered state
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_data  out  XLEN  register-file write data (registered)

Behaviour:
- Reset (rst=0 at clk edge):
  - count, head, tail and starve counter = 0.
  - rf_we=0, rf_rd=0, rf_data=0.
  - wb_stall=0 and lu_rdy=1 after reset.
- Pipeline request: wb_req = wb_vld && wb_rd≠0. x0 writes never request the port and are dropped silently.
- LU push:
  - Occurs when lu_vld && lu_rdy. Writes entry at tail; tail wraps modulo BUF_DEPTH.
  - lu_vld with lu_rd=0 is accepted and discarded (no push).
  - lu_vld while lu_rdy=0 is ignored; the LU must hold its result.
- Grant decision (combinational, each cycle):
  - force_lu = (count==BUF_DEPTH) || (starve==STARVE_LIMIT)
  - FIFO empty → grant pipeline if wb_req.
  - FIFO non-empty, !wb_req → grant LU (pop head).
  - FIFO non-empty, wb_req, !force_lu → grant pipeline.
  - FIFO non-empty, wb_req, force_lu → grant LU; wb_stall=1.
- wb_stall is asserted only in the last case above.
- Write port: the granted source's rd/data are registered into rf_* at the clock edge, with rf_we=1. With no grant, rf_we=0 and rf_rd/rf_data hold their previous values.
- Latency:
  - Pipeline write: visible on rf_* one cycle after wb_req.
  - LU result pushed at edge N: may be popped in cycle N+1 and is visible on rf_* after edge N+1, i.e. minimum 2 cycles.
  - The FIFO has no bypass.
- Simultaneous push and pop in one cycle:
  - Allowed whenever lu_rdy=1; count unchanged.
  - When full, lu_rdy=0, so a pop frees the slot for the next cycle only.
- Starve counter:
  - +1 each cycle the FIFO is non-empty and the LU is not granted; saturates at STARVE_LIMIT.
  - Clears to 0 on any LU grant or when the FIFO is empty.
- Ordering between LU and pipeline writes to the same rd is not resolved here; issue logic (scoreboard) guarantees no WAW overlap.
- Reset mid-operation: FIFO contents are discarded (count=0), and rf_we=0 on the following cycle.

Decomposition:
- Shared package sys_defs additions:
  - ZERO_REG (existing)
  - WB_PORT_PIPE / WB_PORT_LU grant encoding
  - a wb_req_t struct {vld, rd[4:0], data[XLEN-1:0]}
- Natural sub-module: wb_lu_fifo, a parameterised sync FIFO with count, wrap-around pointers and full/empty flags.
- Arbitration, starve counter and output register stay in wb_port_arbiter.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with wb_vld=1 → rf_we=0, rf_rd=0, rf_data=0, lu_rdy=1, wb_stall=0. After release, wb_rd=5, wb_data=0xA5A5_0001 → next cycle rf_we=1, rf_rd=5, rf_data=0xA5A5_0001.
2. x0 drop: wb_vld=1, wb_rd=0; lu_vld=1, lu_rd=0 → rf_we stays 0, FIFO count stays 0, no stall.
3. Idle-port LU: push lu_rd=7, data 0x1234 with pipeline idle → rf_we=1, rf_rd=7 exactly 2 cycles after push.
4. Starvation: one LU entry queued, wb_req held continuously, STARVE_LIMIT=4 → pipeline writes for 4 cycles; in the 5th cycle wb_stall=1 and the LU entry is written; the held pipeline write lands the following cycle.
5. Full FIFO:
   - Push 2 entries back-to-back while wb_req=1 → lu_rdy=0 and wb_stall=1 the next cycle.
   - Extra lu_vld is not accepted.
   - Entries drain in push order (rd 3 then rd 4).
   - Pointers wrap: a 3rd push lands at index 0.
6. Reset mid-operation: 2 entries queued, rst=0 for one cycle → count=0, lu_rdy=1, rf_we=0 next cycle, and no stale LU write ever appears.
